// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the multi-channel breathing LED PWM driver.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_FIXED   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // Reset ramp level of channel k: channels spread evenly over the counter range.
  function automatic int unsigned phase_init(int unsigned k, int unsigned nch, int unsigned cw);
    return (k * (32'd1 << cw)) / nch;
  endfunction

endpackage

// File: rtl/tri_ramp.sv
// Triangle ramp for one channel: level walks 0..max..0, holding each extreme for one step.
module tri_ramp
  import led_pwm_pkg::*;
#(
  parameter int unsigned CW   = 8,
  parameter int unsigned INIT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_step,
  output logic [CW-1:0] o_level_nxt
);

  localparam logic [CW-1:0] LVL_MAX  = '1;
  localparam logic [CW-1:0] LVL_INIT = CW'(INIT);

  logic [CW-1:0] r_level;
  logic          r_down;
  logic [CW-1:0] w_level_nxt;
  logic          w_down_nxt;

  always_comb begin
    w_level_nxt = r_level;
    w_down_nxt  = r_down;
    if (i_step) begin
      if (r_down) begin
        w_level_nxt = r_level - 1'b1;
        if (w_level_nxt == '0) w_down_nxt = 1'b0;
      end else begin
        w_level_nxt = r_level + 1'b1;
        if (w_level_nxt == LVL_MAX) w_down_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level <= LVL_INIT;
      r_down  <= (LVL_INIT == LVL_MAX);
    end else begin
      r_level <= w_level_nxt;
      r_down  <= w_down_nxt;
    end
  end

  // Post-step level, so a boundary that steps also selects the stepped value.
  assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/led_breathe_pwm.sv
// Multi-channel PWM LED driver: shared period counter, staggered triangle breathing,
// fixed/blink/off modes; all duty changes are applied only at period boundaries.
module led_breathe_pwm
  import led_pwm_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CW         = 8,
  parameter int unsigned SW         = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic [1:0]     i_mode,
  input  logic [SW-1:0]  i_step_div,
  input  logic [CW-1:0]  i_duty_fix,
  output logic [NCH-1:0] o_led,
  output logic           o_period_start
);

  logic [CW-1:0]  r_pwm_cnt;
  logic [SW-1:0]  r_presc;
  logic [SW-1:0]  r_step_div;
  logic           r_blink;
  logic           r_armed;
  logic [CW-1:0]  r_duty [NCH];
  logic [NCH-1:0] r_led;
  logic           r_period_start;

  logic           w_bnd;
  logic           w_tick;
  logic           w_blink_nxt;
  logic [CW-1:0]  w_lvl_nxt  [NCH];
  logic [CW-1:0]  w_duty_nxt [NCH];

  assign w_bnd       = i_en && (r_pwm_cnt == '1);
  assign w_tick      = w_bnd && (r_presc == r_step_div);
  assign w_blink_nxt = r_blink ^ w_tick;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tri_ramp #(
      .CW   (CW),
      .INIT (phase_init(k, NCH, CW))
    ) u_ramp (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_step      (w_tick),
      .o_level_nxt (w_lvl_nxt[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_duty_nxt[k] = '0;
      unique case (mode_e'(i_mode))
        MODE_OFF:     w_duty_nxt[k] = '0;
        MODE_FIXED:   w_duty_nxt[k] = i_duty_fix;
        MODE_BREATHE: w_duty_nxt[k] = w_lvl_nxt[k];
        MODE_BLINK:   w_duty_nxt[k] = {CW{w_blink_nxt}};
        default:      w_duty_nxt[k] = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pwm_cnt      <= '0;
      r_presc        <= '0;
      r_step_div     <= '0;
      r_blink        <= 1'b0;
      r_armed        <= 1'b0;
      r_led          <= {NCH{ACTIVE_LOW}};
      r_period_start <= 1'b0;
      for (int k = 0; k < NCH; k++) r_duty[k] <= '0;
    end else begin
      if (i_en) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
        for (int k = 0; k < NCH; k++) r_led[k] <= (r_pwm_cnt < r_duty[k]) ^ ACTIVE_LOW;
        // The post-reset counter-0 cycle precedes any latched duty, so it is not announced.
        r_period_start <= r_armed && (r_pwm_cnt == '0);
      end else begin
        r_led          <= {NCH{ACTIVE_LOW}};
        r_period_start <= 1'b0;
      end
      if (w_bnd) begin
        r_presc    <= w_tick ? '0 : r_presc + 1'b1;
        r_step_div <= i_step_div;
        r_blink    <= w_blink_nxt;
        r_armed    <= 1'b1;
        r_duty     <= w_duty_nxt;
      end
    end
  end

  assign o_led          = r_led;
  assign o_period_start = r_period_start;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm: active-high and active-low instances share stimulus and are
// compared against a period-level model of the ramps, prescaler and duty selection.
module tb_led_breathe_pwm;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned SW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [1:0]     mode;
  logic [SW-1:0]  step_div;
  logic [CW-1:0]  duty_fix;
  logic [NCH-1:0] led0, led1;
  logic           ps0, ps1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_breathe_pwm #(.NCH(NCH), .CW(CW), .SW(SW), .ACTIVE_LOW(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_step_div(step_div),
    .i_duty_fix(duty_fix), .o_led(led0), .o_period_start(ps0)
  );

  led_breathe_pwm #(.NCH(NCH), .CW(CW), .SW(SW), .ACTIVE_LOW(1'b1)) dut_al (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_step_div(step_div),
    .i_duty_fix(duty_fix), .o_led(led1), .o_period_start(ps1)
  );

  // Model: each channel is a position on a 30-step triangle; level is read off it.
  int             m_cnt, m_presc, m_sd;
  int             m_pos  [NCH];
  int             m_duty [NCH];
  bit             m_blink, m_armed;
  logic [NCH-1:0] exp_led;
  logic           exp_ps;

  function automatic int tri_lvl(int pos);
    int p;
    p = pos % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  task automatic cyc();
    bit tick;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_sd = 0; m_blink = 1'b0; m_armed = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_pos[k]  = k * 16 / NCH;
        m_duty[k] = 0;
      end
      exp_led = '0;
      exp_ps  = 1'b0;
    end else if (en) begin
      for (int k = 0; k < NCH; k++) exp_led[k] = (m_cnt < m_duty[k]);
      exp_ps = (m_cnt == 0) && m_armed;
      if (m_cnt == 15) begin
        m_armed = 1'b1;
        tick    = (m_presc == m_sd);
        m_presc = tick ? 0 : (m_presc + 1) % 16;
        m_sd    = int'(step_div);
        if (tick) begin
          m_blink = !m_blink;
          for (int k = 0; k < NCH; k++) m_pos[k] = (m_pos[k] + 1) % 30;
        end
        for (int k = 0; k < NCH; k++) begin
          case (mode)
            2'd0:    m_duty[k] = 0;
            2'd1:    m_duty[k] = int'(duty_fix);
            2'd2:    m_duty[k] = tri_lvl(m_pos[k]);
            default: m_duty[k] = m_blink ? 15 : 0;
          endcase
        end
      end
      m_cnt = (m_cnt + 1) % 16;
    end else begin
      exp_led = '0;
      exp_ps  = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      cyc();
      if (ps0 === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    en = 1'b1; mode = 2'd0; step_div = '0; duty_fix = '0;
    do_reset();
    n_vec++;
    if (led0 !== 4'b0000 || led1 !== 4'b1111 || ps0 !== 1'b0 || ps1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: led=%b/%b ps=%b/%b required led=0000/1111 ps=0",
               led0, led1, ps0, ps1);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      cyc(); n++;
      n_vec++;
      if (led0 !== exp_led || led1 !== ~exp_led || ps0 !== exp_ps || ps1 !== exp_ps) begin
        n_fail++;
        $display("FAIL reset_release: led=%b/%b ps=%b/%b required led=%b/%b ps=%b",
                 led0, led1, ps0, ps1, exp_led, ~exp_led, exp_ps);
      end
      if (ps0 === 1'b1) seen = 1'b1;
    end
    // n counts edges from the first un-reset edge; the pulse lands 16 cycles after it.
    n_vec++;
    if (!seen || n != 17) begin
      n_fail++;
      $display("FAIL first_period_start: edges=%0d seen=%0b required edges=17", n, seen);
    end
  endtask

  task automatic test_fixed();
    int duties [3];
    bit ok;
    logic [NCH-1:0] want;
    duties[0] = 5; duties[1] = 0; duties[2] = 15;
    en = 1'b1; mode = 2'd1; duty_fix = 4'd5; step_div = '0;
    do_reset();
    wait_ps(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL fixed_ps_timeout: seen=0 required seen=1"); end
    for (int d = 0; d < 3; d++) begin
      duty_fix = 4'(duties[(d + 1) % 3]);
      for (int i = 0; i < 16; i++) begin
        want = (i < duties[d]) ? 4'b1111 : 4'b0000;
        n_vec++;
        if (led0 !== want || led1 !== ~want) begin
          n_fail++;
          $display("FAIL fixed_duty%0d_cyc%0d: led=%b/%b required %b/%b",
                   duties[d], i, led0, led1, want, ~want);
        end
        cyc();
      end
      n_vec++;
      if (ps0 !== 1'b1 || ps1 !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_period_len: ps=%b/%b required 1", ps0, ps1);
      end
    end
  endtask

  task automatic test_breathe();
    int ht [NCH];
    bit ok;
    en = 1'b1; mode = 2'd2; duty_fix = '0; step_div = '0;
    do_reset();
    wait_ps(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL breathe_ps_timeout: seen=0 required seen=1"); end
    for (int p = 0; p < 31; p++) begin
      for (int k = 0; k < NCH; k++) ht[k] = 0;
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < NCH; k++) ht[k] += int'(led0[k]);
        n_vec++;
        if (led0 !== exp_led || led1 !== ~exp_led) begin
          n_fail++;
          $display("FAIL breathe_cyc: led=%b/%b required %b/%b", led0, led1, exp_led, ~exp_led);
        end
        cyc();
      end
      for (int k = 0; k < NCH; k++) begin
        n_vec++;
        if (ht[k] != tri_lvl(4 * k + 1 + p)) begin
          n_fail++;
          $display("FAIL breathe_ht ch%0d period%0d: high=%0d required %0d",
                   k, p, ht[k], tri_lvl(4 * k + 1 + p));
        end
      end
      n_vec++;
      if (ps0 !== 1'b1) begin
        n_fail++; $display("FAIL breathe_period_start: ps=%b required 1", ps0);
      end
    end
  endtask

  task automatic test_rate_blink();
    int ht [12];
    bit ok;
    logic [NCH-1:0] want;
    en = 1'b1; mode = 2'd1; duty_fix = 4'd6; step_div = 4'd2;
    do_reset();
    wait_ps(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL blink_ps_timeout: seen=0 required seen=1"); end
    for (int i = 0; i < 16; i++) begin
      if (m_cnt == 7) mode = 2'd3;
      want = (i < 6) ? 4'b1111 : 4'b0000;
      n_vec++;
      if (led0 !== want || led1 !== ~want) begin
        n_fail++;
        $display("FAIL blink_switch_cyc%0d: led=%b/%b required %b/%b", i, led0, led1, want, ~want);
      end
      cyc();
    end
    for (int p = 0; p < 12; p++) begin
      ht[p] = 0;
      for (int i = 0; i < 16; i++) begin
        ht[p] += int'(led0[0]);
        n_vec++;
        if (led0 !== exp_led || led1 !== ~exp_led || ps0 !== exp_ps) begin
          n_fail++;
          $display("FAIL blink_cyc: led=%b/%b ps=%b required %b/%b ps=%b",
                   led0, led1, ps0, exp_led, ~exp_led, exp_ps);
        end
        cyc();
      end
      n_vec++;
      if (ht[p] != 0 && ht[p] != 15) begin
        n_fail++; $display("FAIL blink_level p%0d: high=%0d required 0 or 15", p, ht[p]);
      end
      if (p >= 3) begin
        n_vec++;
        if (ht[p] != 15 - ht[p - 3]) begin
          n_fail++;
          $display("FAIL blink_rate p%0d: high=%0d required %0d", p, ht[p], 15 - ht[p - 3]);
        end
      end
    end
  endtask

  task automatic test_freeze();
    bit ok;
    en = 1'b1; mode = 2'd2; step_div = '0;
    do_reset();
    wait_ps(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL freeze_ps_timeout: seen=0 required seen=1"); end
    repeat ($urandom_range(20, 60)) cyc();
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_vec++;
      if (led0 !== 4'b0000 || led1 !== 4'b1111 || ps0 !== 1'b0 || ps1 !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_cyc%0d: led=%b/%b ps=%b/%b required 0000/1111 ps=0",
                 i, led0, led1, ps0, ps1);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      cyc();
      n_vec++;
      if (led0 !== exp_led || led1 !== ~exp_led || ps0 !== exp_ps || ps1 !== exp_ps) begin
        n_fail++;
        $display("FAIL freeze_resume: led=%b/%b ps=%b/%b required %b/%b ps=%b",
                 led0, led1, ps0, ps1, exp_led, ~exp_led, exp_ps);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int ht [NCH];
    en = 1'b1; mode = 2'd2; step_div = '0;
    do_reset();
    repeat ($urandom_range(40, 90)) cyc();
    while (m_cnt != 9) cyc();
    rst_n = 1'b0;
    cyc();
    n_vec++;
    if (led0 !== 4'b0000 || led1 !== 4'b1111 || ps0 !== 1'b0 || ps1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: led=%b/%b ps=%b/%b required 0000/1111 ps=0",
               led0, led1, ps0, ps1);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    wait_ps(ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL mid_reset_ps_timeout: seen=0 required seen=1"); end
    for (int k = 0; k < NCH; k++) ht[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NCH; k++) ht[k] += int'(led0[k]);
      cyc();
    end
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (ht[k] != 4 * k + 1) begin
        n_fail++;
        $display("FAIL mid_reset_level ch%0d: high=%0d required %0d", k, ht[k], 4 * k + 1);
      end
    end
  endtask

  task automatic test_random();
    en = 1'b1; mode = 2'($urandom_range(0, 3)); duty_fix = 4'($urandom);
    step_div = 4'($urandom_range(0, 3));
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) duty_fix = 4'($urandom);
      if ($urandom_range(0, 63) == 0) step_div = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) en = ~en;
      cyc();
      n_vec++;
      if (led0 !== exp_led || led1 !== ~exp_led || ps0 !== exp_ps || ps1 !== exp_ps) begin
        n_fail++;
        $display("FAIL random_c%0d: led=%b/%b ps=%b/%b required %b/%b ps=%b",
                 c, led0, led1, ps0, ps1, exp_led, ~exp_led, exp_ps);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached required bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; step_div = '0; duty_fix = '0;
    exp_led = '0; exp_ps = 1'b0;
    #2;
    test_reset();
    test_fixed();
    test_breathe();
    test_rate_blink();
    test_freeze();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/led_breathe_pwm.md
# led_breathe_pwm

Multi-channel PWM LED driver for the board LED bank, generalising the single-channel breathing-LED PWM. One shared PWM period counter drives NCH channels. Each channel has its own triangle-ramp duty level with a fixed phase offset, so the LEDs breathe in a staggered wave. Fixed-duty, blink and off modes are selectable at run time, and all duty, mode and rate changes are glitch-free.

## Interface
- NCH, 4: number of LED channels (1..16)
- CW, 8: duty/PWM counter width; PWM period = 2^CW clk cycles
- SW, 16: width of step prescaler (PWM periods per ramp step)
- ACTIVE_LOW, 0: 1 inverts all led outputs (inactive level = 1)

- clk  in  1  system clock (50 MHz on board)
- rst_n  in  1  synchronous reset, active-low
- en  in  1  1 = run; 0 = freeze all counters, led inactive
- mode  in  2  0 OFF, 1 FIXED, 2 BREATHE, 3 BLINK
- step_div  in  SW  ramp step every step_div+1 PWM periods
- duty_fix  in  CW  duty used in FIXED mode (all channels)
- led  out  NCH  PWM outputs, registered
- period_start  out  1  one-cycle pulse when pwm counter = 0 (registered, aligned with led)

## Operation
- pwm_cnt: CW-bit free-running up counter, wraps 2^CW-1 -> 0. The boundary is the cycle where pwm_cnt = 2^CW-1 and en = 1.
- At the boundary, latch mode_q, step_div_q, duty_fix_q and per-channel duty_q[k]. Inputs changed mid-period have no effect until the next period.
- Prescaler: SW-bit counter of boundaries. When it equals step_div_q it clears and asserts step_tick for that boundary. step_div = 0 gives a tick every period.
- Ramp per channel: level[k] (CW bits) and dir[k] (up/down).
  - On step_tick going up: level+1; when level reaches 2^CW-1, dir flips to down.
  - On step_tick going down: level-1; when level reaches 0, dir flips to up.
  - Each extreme is held for exactly one step. Full triangle = 2*(2^CW-1) steps.
- Ramps advance in every mode, so re-entering BREATHE continues the wave.
- blink_q toggles on each step_tick.
- Duty selection at the boundary:
  - OFF: duty 0.
  - FIXED: duty_fix_q.
  - BREATHE: level[k] (post-update value).
  - BLINK: 2^CW-1 if blink_q else 0.
- Output: led[k] = (pwm_cnt < duty_q[k]), XOR ACTIVE_LOW, registered.
  - Duty 0 keeps the output inactive for the whole period.
  - Duty 2^CW-1 keeps it active for 2^CW-1 of 2^CW cycles (never 100 %).
- en = 0: pwm_cnt, prescaler, ramps and blink_q hold; led forced inactive next cycle; period_start = 0. When en returns to 1, counting resumes from the held values.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - pwm_cnt = 0, prescaler = 0, blink_q = 0
  - level[k] = (k*2^CW)/NCH, integer division; dir[k] = up; a level equal to 2^CW-1 after reset starts with dir = down
  - duty_q = 0, mode_q = OFF, led = inactive, period_start = 0
- Reset takes priority over en and over all events. Mid-operation reset returns to the reset state on the next edge.
- Latency:
  - led reflects pwm_cnt one cycle later.
  - A new duty takes effect on the first led cycle of the following period: period_start and the first cycle of the new duty coincide.
- If a step_tick and a mode change share a boundary, the new mode uses the post-step level/blink_q.

## Structure
- Package led_pwm_pkg: mode enum (MODE_OFF, MODE_FIXED, MODE_BREATHE, MODE_BLINK) and a helper function for the reset phase offset.
- Sub-module tri_ramp (params CW, INIT), holding level/dir and the step logic, instantiated NCH times via generate. The top level holds pwm_cnt, the prescaler, the latches and the comparators.

## Test plan
All scenarios use CW = 4, NCH = 4, SW = 4.
- Reset: hold rst_n = 0 for 3 cycles, then release.
  - Required: led = 0000 and period_start = 0.
  - Required: internal levels = 0, 4, 8, 12.
  - Required: first period_start 16 cycles after release (counter 0 latched under OFF, then the first boundary).
- FIXED with duty_fix = 5, en = 1.
  - Required: every led high for exactly 5 cycles starting at period_start, low for 11, period 16.
  - Required: duty_fix = 0 gives led constantly 0; duty_fix = 15 gives 15 of 16 cycles high.
- BREATHE with step_div = 0.
  - Required ch0 high-times per period: 1, 2, …, 15, 14, …, 0, 1 (30-period cycle).
  - Required: ch2 starts at 9, reaches 15, then descends to 14.
- Rate and mid-period change: set step_div = 2, then switch mode from FIXED to BLINK at pwm_cnt = 7.
  - Required: led pattern unchanged until the next period_start.
  - Required: the blink state toggles every 3 periods, each period showing a high-time of either 15 or 0.
- en freeze: drop en for 40 cycles during BREATHE, then re-assert.
  - Required: led = 0000 within 1 cycle of en dropping; no period_start pulses while en = 0.
  - Required: after re-assertion, the level sequence continues without skipping.
- Reset mid-operation during BREATHE at pwm_cnt = 9.
  - Required: the next edge gives led = 0000 with levels restored to 0, 4, 8, 12.
- Run with ACTIVE_LOW = 1.
  - Required: all of the above levels appear inverted.
